// File: rtl/aes_decrypt_iter_if.sv
// Block/key handshake bundle for the iterative AES inverse cipher.
// slave = datapath side, master = source/sink/key-store side.
interface aes_decrypt_iter_if #(
    parameter int KIW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic [KIW-1:0] key_idx;
    logic [127:0]   round_key;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           busy;

    modport master (
        output in_valid, in_data, round_key, out_ready,
        input  in_ready, key_idx, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, round_key, out_ready,
        output in_ready, key_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one inverse round per clk, round keys fetched by index from an external store.
// Latency NR cycles accept->out_valid; result held while out_ready low, no new accept until it drains.
module aes_decrypt_iter #(
    parameter int NR  = 10,
    parameter int KIW = 4
) (
    input  logic          clk,
    input  logic          reset,
    aes_decrypt_iter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t         fsm;
    logic [127:0]   st;
    logic [KIW-1:0] rc;
    logic           in_ready_r;
    logic           busy_r;
    logic           out_valid_r;
    logic [127:0]   out_data_r;
    logic [127:0]   ark;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] x;
        for (int i = 0; i < 8; i++)
            x[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        return gf_inv(x ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++)
            o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
        return o;
    endfunction

    // byte k = row (k%4), column (k/4); row r rotates right by r columns
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[127 - 32*c - 8  -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[127 - 32*c - 16 -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[127 - 32*c - 24 -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    always_comb begin
        ark = inv_sub_bytes(inv_shift_rows(st)) ^ bus.round_key;
    end

    always_comb begin
        case (fsm)
            IDLE:    bus.key_idx = KIW'(NR);
            ROUND:   bus.key_idx = rc;
            default: bus.key_idx = '0;
        endcase
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm         <= IDLE;
            st          <= '0;
            rc          <= '0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        st         <= bus.in_data ^ bus.round_key;
                        rc         <= KIW'(NR - 1);
                        fsm        <= ROUND;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ROUND: begin
                    if (rc != '0) begin
                        st <= inv_mix_columns(ark);
                        rc <= rc - KIW'(1);
                    end else begin
                        // final round skips InvMixColumns
                        st          <= ark;
                        fsm         <= DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_data_r  <= ark;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm         <= IDLE;
                        out_valid_r <= 1'b0;
                        out_data_r  <= '0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    fsm         <= IDLE;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_data_r  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors, encrypt-model random blocks, backpressure, reset, NR=14 build.
module tb_aes_decrypt_iter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_decrypt_iter_if #(.KIW(4)) b10 ();
    aes_decrypt_iter_if #(.KIW(4)) b14 ();

    aes_decrypt_iter #(.NR(10), .KIW(4)) dut10 (.clk(clk), .reset(reset), .bus(b10));
    aes_decrypt_iter #(.NR(14), .KIW(4)) dut14 (.clk(clk), .reset(reset), .bus(b14));

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic [7:0]   sbox [256];
    logic [127:0] rk10 [16];
    logic [127:0] rk14 [16];

    assign b10.round_key = rk10[b10.key_idx];
    assign b14.round_key = rk14[b14.key_idx];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (forward cipher + key schedule) ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] o;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                o[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
            sbox[x] = o ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (nr == 10) rk10[r] = {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
            else          rk14[r] = {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
        end
    endtask

    function automatic logic [127:0] enc10(input logic [127:0] p);
        logic [127:0] s;
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        s = p ^ rk10[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = sbox[s[127 - 8*k -: 8]];
            s = o;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            s = o;
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32*c -: 8];      a1 = s[119 - 32*c -: 8];
                    a2 = s[111 - 32*c -: 8];      a3 = s[103 - 32*c -: 8];
                    o[127 - 32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    o[103 - 32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
                s = o;
            end
            s = s ^ rk10[rnd];
        end
        return s;
    endfunction

    // ---------------- scoreboard and monitor for the NR=10 instance ----------------
    logic [127:0] exp_q [$];
    logic [127:0] next_exp;
    int cyc      = 0;
    int acc_edge = 0;
    int hs_edge  = 0;
    int exp_rc   = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (b10.in_valid && b10.in_ready) begin
                chk("key_idx_idle", 128'(b10.key_idx), 128'd10);
                exp_q.push_back(next_exp);
                acc_edge = cyc + 1;
                exp_rc   = 9;
            end
            if (b10.busy) begin
                chk("key_idx_round", 128'(b10.key_idx), 128'(exp_rc));
                exp_rc--;
            end
            if (b10.out_valid && !ov_prev)
                chk("latency", 128'(cyc - acc_edge), 128'd10);
            if (b10.out_valid && b10.out_ready) begin
                chk("out_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) chk("out_data", b10.out_data, exp_q.pop_front());
                hs_edge = cyc + 1;
            end
        end
        ov_prev = b10.out_valid;
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [127:0] ct, input logic [127:0] pt);
        bit ok;
        ok = 1'b0;
        b10.in_valid = 1'b1;
        b10.in_data  = ct;
        next_exp     = pt;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (b10.in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        chk("accepted", 128'(ok), 128'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drained", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] p;
        int n;
        int acc14;

        reset         = 1'b1;
        b10.in_valid  = 1'b0;
        b10.in_data   = '0;
        b10.out_ready = 1'b1;
        b14.in_valid  = 1'b0;
        b14.in_data   = '0;
        b14.out_ready = 1'b1;
        next_exp      = '0;
        for (int i = 0; i < 16; i++) begin
            rk10[i] = '0;
            rk14[i] = '0;
        end
        build_sbox();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(b10.in_ready), 128'd1);
        chk("rst_out_valid", 128'(b10.out_valid), 128'd0);
        chk("rst_out_data", b10.out_data, 128'd0);
        chk("rst_busy", 128'(b10.busy), 128'd0);
        chk("rst14_out_valid", 128'(b14.out_valid), 128'd0);
        reset = 1'b0;

        // FIPS-197 C.1
        send(C1_CT, PT);
        b10.in_valid = 1'b0;
        drain();
        chk("c1_valid_one_cycle", 128'(b10.out_valid), 128'd0);
        chk("c1_ready_after", 128'(b10.in_ready), 128'd1);

        // backpressure
        b10.out_ready = 1'b0;
        send(C1_CT, PT);
        b10.in_valid = 1'b0;
        n = 0;
        while (!b10.out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 128'(b10.out_valid), 128'd1);
            chk("bp_data", b10.out_data, PT);
            chk("bp_in_ready", 128'(b10.in_ready), 128'd0);
        end
        b10.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_drop", 128'(b10.out_valid), 128'd0);
        chk("bp_in_ready_back", 128'(b10.in_ready), 128'd1);
        chk("bp_drained", 128'(exp_q.size()), 128'd0);

        // back-to-back with in_valid held
        send(C1_CT, PT);
        send(enc10(128'h0), 128'h0);
        chk("b2b_accept_gap", 128'(acc_edge - hs_edge), 128'd1);
        b10.in_valid = 1'b0;
        drain();

        // reset in the middle of the rounds
        send(C1_CT, PT);
        b10.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_in_ready", 128'(b10.in_ready), 128'd1);
        chk("mid_rst_out_valid", 128'(b10.out_valid), 128'd0);
        chk("mid_rst_out_data", b10.out_data, 128'd0);
        chk("mid_rst_busy", 128'(b10.busy), 128'd0);
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(enc10(p), p);
        b10.in_valid = 1'b0;
        drain();

        // input noise while rounds are running
        send(C1_CT, PT);
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (b10.out_valid) break;
            b10.in_valid = 1'($urandom());
            b10.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        b10.in_valid = 1'b0;
        drain();

        // random blocks, streamed
        for (int i = 0; i < 4; i++) begin
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(enc10(p), p);
        end
        b10.in_valid = 1'b0;
        drain();

        // NR=14 build, FIPS-197 C.3
        b14.in_valid = 1'b1;
        b14.in_data  = C3_CT;
        n = 0;
        @(negedge clk);
        while (!b14.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("c3_in_ready", 128'(b14.in_ready), 128'd1);
        @(posedge clk);
        #1;
        acc14 = cyc;
        b14.in_valid = 1'b0;
        b14.in_data  = '0;
        n = 0;
        while (!b14.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("c3_latency", 128'(cyc - acc14), 128'd14);
        chk("c3_out_data", b14.out_data, PT);
        @(posedge clk);
        #1;
        chk("c3_valid_drop", 128'(b14.out_valid), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
